// File: rtl/spart_driver_fifo.sv
// SPART bus driver: programs the baud divisor from br_cfg and
// echoes received bytes back through an internal FIFO.
module spart_driver_fifo #(
    parameter int DATA_W     = 8,
    parameter int DIV_W      = 16,
    parameter int DIV0       = 650,
    parameter int DIV1       = 325,
    parameter int DIV2       = 162,
    parameter int DIV3       = 80,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    br_cfg,
    input  logic                          rda,
    input  logic                          tbr,
    output logic                          iocs,
    output logic                          iorw,
    output logic [1:0]                    ioaddr,
    inout  wire  [DATA_W-1:0]             databus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          prog_done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] A_DATA = 2'b00;
    localparam logic [1:0] A_TX   = 2'b01;
    localparam logic [1:0] A_DBLO = 2'b10;
    localparam logic [1:0] A_DBHI = 2'b11;

    typedef enum logic [2:0] {
        PROG_LO,
        PROG_HI,
        IDLE,
        RD,
        WR
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [1:0]          br_cfg_q;
    logic                mismatch;
    logic                full;
    logic                empty;
    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic [DIV_W-1:0]    div_sel;
    logic [15:0]         div_ext;
    logic [DATA_W-1:0]   dout;
    logic                drive;

    assign mismatch   = (br_cfg != br_cfg_q);
    assign full       = (count == CW'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign fifo_count = count;
    assign div_ext    = 16'(div_sel);
    assign drive      = iocs && !iorw;
    assign databus    = drive ? dout : {DATA_W{1'bz}};

    // Divisor chosen from the registered baud select
    always_comb begin
        div_sel = DIV_W'(DIV0);
        unique case (br_cfg_q)
            2'b00: div_sel = DIV_W'(DIV0);
            2'b01: div_sel = DIV_W'(DIV1);
            2'b10: div_sel = DIV_W'(DIV2);
            2'b11: div_sel = DIV_W'(DIV3);
        endcase
    end

    // State register and baud-select history
    always_ff @(posedge clk) begin
        br_cfg_q <= br_cfg;
        if (rst) state <= PROG_LO;
        else     state <= state_nx;
    end

    // Next state: a baud change always restarts programming
    always_comb begin
        state_nx = state;
        unique case (state)
            PROG_LO: state_nx = PROG_HI;
            PROG_HI: state_nx = IDLE;
            IDLE: begin
                if (rda && !full)       state_nx = RD;
                else if (tbr && !empty) state_nx = WR;
                else                    state_nx = IDLE;
            end
            RD:      state_nx = IDLE;
            WR:      state_nx = IDLE;
            default: state_nx = PROG_LO;
        endcase
        if (mismatch) state_nx = PROG_LO;
    end

    // Moore bus decode; reset forces the bus quiet immediately
    always_comb begin
        iocs   = 1'b0;
        iorw   = 1'b1;
        ioaddr = A_DATA;
        dout   = '0;
        if (!rst) begin
            unique case (state)
                PROG_LO: begin
                    iocs   = 1'b1;
                    iorw   = 1'b0;
                    ioaddr = A_DBLO;
                    dout   = DATA_W'(div_ext[7:0]);
                end
                PROG_HI: begin
                    iocs   = 1'b1;
                    iorw   = 1'b0;
                    ioaddr = A_DBHI;
                    dout   = DATA_W'(div_ext[15:8]);
                end
                RD: begin
                    iocs   = 1'b1;
                    iorw   = 1'b1;
                    ioaddr = A_DATA;
                end
                WR: begin
                    iocs   = 1'b1;
                    iorw   = 1'b0;
                    ioaddr = A_TX;
                    dout   = mem[rd_ptr];
                end
                default: ;
            endcase
        end
    end

    // Status flags: prog_done tracks the current divisor, overflow is sticky
    always_ff @(posedge clk) begin
        if (rst) begin
            prog_done <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (mismatch)            prog_done <= 1'b0;
            else if (state == PROG_HI) prog_done <= 1'b1;
            if (state == IDLE && rda && full) overflow <= 1'b1;
        end
    end

    // FIFO pointers and occupancy; RD and WR are exclusive states
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (state == RD) begin
            wr_ptr <= wr_ptr + AW'(1);
            count  <= count + CW'(1);
        end else if (state == WR) begin
            rd_ptr <= rd_ptr + AW'(1);
            count  <= count - CW'(1);
        end
    end

    // FIFO storage captures the SPART byte during RD
    always_ff @(posedge clk) begin
        if (!rst && state == RD) mem[wr_ptr] <= databus;
    end

endmodule

// File: tb/tb_spart_driver_fifo.sv
// Randomized bench for spart_driver_fifo with a queue-based
// transaction model of the SPART bus accesses.
module tb_spart_driver_fifo;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst;
    logic [1:0]  br_cfg;
    logic        rda;
    logic        tbr;
    logic        iocs;
    logic        iorw;
    logic [1:0]  ioaddr;
    wire  [7:0]  databus;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic        prog_done;
    logic [7:0]  rx_byte;

    int n_checks;
    int n_fail;

    spart_driver_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .br_cfg     (br_cfg),
        .rda        (rda),
        .tbr        (tbr),
        .iocs       (iocs),
        .iorw       (iorw),
        .ioaddr     (ioaddr),
        .databus    (databus),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .prog_done  (prog_done)
    );

    // The SPART side drives the bus whenever it is being read
    assign databus = (iocs && iorw) ? rx_byte : 8'bz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum {ACC_NONE, ACC_LO, ACC_HI, ACC_RD, ACC_WR} acc_t;

    acc_t       cur;
    logic [7:0] q [$];
    logic [1:0] m_cfg;
    logic       m_done;
    logic       m_ovf;
    int         div_tab [4] = '{650, 325, 162, 80};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] div_of(input logic [1:0] c);
        return 16'(div_tab[c]);
    endfunction

    // Advance the model by one clock edge using the current inputs
    task automatic model_step();
        bit   mis;
        acc_t nxt;
        if (rst) begin
            cur    = ACC_LO;
            q      = {};
            m_done = 1'b0;
            m_ovf  = 1'b0;
            m_cfg  = br_cfg;
            return;
        end
        mis = (br_cfg != m_cfg);
        nxt = ACC_NONE;
        case (cur)
            ACC_LO: nxt = ACC_HI;
            ACC_HI: begin
                nxt = ACC_NONE;
                m_done = 1'b1;
            end
            ACC_RD: q.push_back(rx_byte);
            ACC_WR: void'(q.pop_front());
            default: begin
                if (rda && q.size() == DEPTH) m_ovf = 1'b1;
                if (rda && q.size() < DEPTH)  nxt = ACC_RD;
                else if (tbr && q.size() > 0) nxt = ACC_WR;
            end
        endcase
        if (mis) begin
            nxt    = ACC_LO;
            m_done = 1'b0;
        end
        cur   = nxt;
        m_cfg = br_cfg;
    endtask

    task automatic model_check();
        logic [15:0] d;
        d = div_of(m_cfg);
        if (rst || cur == ACC_NONE) begin
            chk("iocs", 32'(iocs), 32'd0);
            chk("iorw", 32'(iorw), 32'd1);
            chk("ioaddr", 32'(ioaddr), 32'd0);
            chk("db_z", {24'd0, databus}, {24'd0, 8'bz});
        end else begin
            chk("iocs", 32'(iocs), 32'd1);
            case (cur)
                ACC_LO: begin
                    chk("iorw", 32'(iorw), 32'd0);
                    chk("ioaddr", 32'(ioaddr), 32'd2);
                    chk("db_lo", 32'(databus), 32'(d[7:0]));
                end
                ACC_HI: begin
                    chk("iorw", 32'(iorw), 32'd0);
                    chk("ioaddr", 32'(ioaddr), 32'd3);
                    chk("db_hi", 32'(databus), 32'(d[15:8]));
                end
                ACC_RD: begin
                    chk("iorw", 32'(iorw), 32'd1);
                    chk("ioaddr", 32'(ioaddr), 32'd0);
                end
                default: begin
                    chk("iorw", 32'(iorw), 32'd0);
                    chk("ioaddr", 32'(ioaddr), 32'd1);
                    chk("db_tx", 32'(databus), 32'(q[0]));
                end
            endcase
        end
        chk("count", 32'(fifo_count), 32'(q.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("prog_done", 32'(prog_done), 32'(m_done));
    endtask

    // One clock: check on the falling edge, then step on the rising edge
    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        br_cfg   = 2'b01;
        rda      = 1'b0;
        tbr      = 1'b0;
        rx_byte  = 8'h00;
        @(posedge clk);
        model_step();
        #1;
        tick();
        rst = 1'b0;
        #1;
        chk("rel_lo_addr", 32'(ioaddr), 32'd2);
        chk("rel_lo_db", 32'(databus), 32'h45);
        tick();
        chk("rel_hi_db", 32'(databus), 32'h01);
        tick();
        chk("rel_idle", 32'(iocs), 32'd0);
        chk("rel_done", 32'(prog_done), 32'd1);

        rx_byte = 8'hA5;
        rda = 1'b1;
        tick();
        rda = 1'b0;
        tick();
        chk("rx1_count", 32'(fifo_count), 32'd1);
        rx_byte = 8'h3C;
        rda = 1'b1;
        tick();
        rda = 1'b0;
        tick();
        chk("rx2_count", 32'(fifo_count), 32'd2);

        br_cfg = 2'b11;
        tick();
        chk("rp_done_lo", 32'(prog_done), 32'd0);
        chk("rp_lo_db", 32'(databus), 32'h50);
        tick();
        chk("rp_hi_db", 32'(databus), 32'h00);
        tick();
        chk("rp_done", 32'(prog_done), 32'd1);
        chk("rp_count", 32'(fifo_count), 32'd2);

        tbr = 1'b1;
        tick();
        chk("tx1_db", 32'(databus), 32'hA5);
        tick();
        tick();
        chk("tx2_db", 32'(databus), 32'h3C);
        tick();
        chk("tx_empty", 32'(fifo_count), 32'd0);
        tbr = 1'b0;
        ticks(2);

        rda = 1'b1;
        for (int i = 0; i < 24; i++) begin
            rx_byte = 8'($urandom);
            tick();
        end
        chk("fill_count", 32'(fifo_count), 32'd8);
        chk("fill_ovf", 32'(overflow), 32'd1);
        chk("fill_quiet", 32'(iocs), 32'd0);
        tbr = 1'b1;
        ticks(10);
        rda = 1'b0;
        ticks(24);
        chk("drain_count", 32'(fifo_count), 32'd0);
        tbr = 1'b0;

        br_cfg = 2'b00;
        ticks(2);
        br_cfg = 2'b10;
        tick();
        chk("abort_db", 32'(databus), 32'hA2);
        chk("abort_done", 32'(prog_done), 32'd0);
        ticks(3);

        rda = 1'b1;
        tbr = 1'b1;
        ticks(5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rda = 1'b0;
        tbr = 1'b0;
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        #1;
        chk("rst_restart", 32'(ioaddr), 32'd2);

        for (int i = 0; i < 3000; i++) begin
            rda     = ($urandom % 3) == 0;
            tbr     = ($urandom % 3) == 0;
            rx_byte = 8'($urandom);
            if (($urandom % 200) == 0) br_cfg = 2'($urandom);
            rst     = ($urandom % 500) == 0;
            tick();
        end
        rst = 1'b0;
        ticks(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
